tmr_vote_monitor: RTL and testbench

Fan-in counterpart to the triplication buffers. Takes three copies of a triplicated bus, produces one registered majority-voted word, and detects copy disagreements. Each disagreement is reported through a single-entry valid/ready event port and counted in a saturating error counter. A periodic scrub strobe tells upstream triplicated registers to reload from the voted value. Sits at the boundary where triplicated logic drives non-triplicated (`do_not_triplicate`) logic.

---
 rtl/tmr_pkg.sv | 18 +
 rtl/majority3.sv | 20 ++
 rtl/tmr_vote_monitor.sv | 248 ++++++++++++++++++++++++
 tb/tb_tmr_vote_monitor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR voting boundary logic.
// Contents:
//   TMR_COPY_A/B/C/MULTI : 2-bit identifiers of the copy that disagreed
//   tmr_state_e          : scrub sequencer states (RUN, SCRUB_ASAP, SCRUB)
package tmr_pkg;

  localparam logic [1:0] TMR_COPY_A     = 2'd0;
  localparam logic [1:0] TMR_COPY_B     = 2'd1;
  localparam logic [1:0] TMR_COPY_C     = 2'd2;
  localparam logic [1:0] TMR_COPY_MULTI = 2'd3;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    SCRUB_ASAP = 2'd1,
    SCRUB      = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/majority3.sv
// Combinational bitwise 2-of-3 voter.
// Ports:
//   a, b, c  in  WIDTH : the three copies
//   vote     out WIDTH : per-bit majority
//   mismatch out WIDTH : bits where the copies are not all equal
module majority3 #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] vote,
  output logic [WIDTH-1:0] mismatch
);

  assign vote     = (a & b) | (b & c) | (a & c);
  // If a==b and b==c then all three agree, so two XORs cover every case.
  assign mismatch = (a ^ b) | (b ^ c);

endmodule

// File: rtl/tmr_vote_monitor.sv
// Majority voter and disagreement monitor at the triplicated /
// non-triplicated boundary.
// Optional feature macro: TMR_VOTE_MONITOR_ERRCNT_EN (error counter and
// err_clr; when undefined err_cnt is tied to zero and err_clr is ignored).
// Ports:
//   clk, rstn              : clock (rising edge), async active-low reset
//   in_a/in_b/in_c, in_valid : triplicated input copies and qualifier
//   out, out_valid         : registered voted word, updated on valid input
//   err_valid/err_ready    : single-entry error event handshake
//   err_mask, err_copy     : disagreeing bits and offending copy of the event
//   err_ovf                : sticky, an event was dropped while the entry was full
//   err_cnt, err_clr       : saturating event counter and its synchronous clear
//   scrub                  : one-cycle strobe asking upstream copies to reload
module tmr_vote_monitor
  import tmr_pkg::*;
#(
  parameter int WIDTH        = 6,
  parameter int CNT_W        = 8,
  parameter int SCRUB_PERIOD = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [WIDTH-1:0] err_mask,
  output logic [1:0]       err_copy,
  output logic             err_ovf,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr,
  output logic             scrub
);

  localparam int SCNT_W = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;
  // The SCRUB cycle itself closes the period, so RUN leaves one step early.
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SCRUB_PERIOD - 2);

  // Names the copy that is the minority on every disagreeing bit, or MULTI.
  function automatic logic [1:0] classify_copy(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c,
    input logic [WIDTH-1:0] m
  );
    logic [1:0] id;
    if (m == ((a ^ b) & (a ^ c))) begin
      id = TMR_COPY_A;
    end else if (m == ((b ^ a) & (b ^ c))) begin
      id = TMR_COPY_B;
    end else if (m == ((c ^ a) & (c ^ b))) begin
      id = TMR_COPY_C;
    end else begin
      id = TMR_COPY_MULTI;
    end
    return id;
  endfunction

  logic [WIDTH-1:0]  vote_s;
  logic [WIDTH-1:0]  mismatch_s;
  logic [1:0]        copy_s;
  logic              event_s;
  logic              drain_s;
  logic              load_s;
  logic              drop_s;

  logic [WIDTH-1:0]  out_r;
  logic              out_valid_r;
  logic              err_valid_r;
  logic [WIDTH-1:0]  err_mask_r;
  logic [1:0]        err_copy_r;
  logic              err_ovf_r;
  logic              scrub_r;

  tmr_state_e        state_r;
  tmr_state_e        state_s;
  logic [SCNT_W-1:0] scnt_r;
  logic [SCNT_W-1:0] scnt_s;

  majority3 #(.WIDTH(WIDTH)) u_majority3 (
    .a        (in_a),
    .b        (in_b),
    .c        (in_c),
    .vote     (vote_s),
    .mismatch (mismatch_s)
  );

  assign event_s = in_valid & (|mismatch_s);
  assign drain_s = err_valid_r & err_ready;
  // A draining entry frees its slot in the same cycle: back-to-back loads.
  assign load_s  = event_s & (~err_valid_r | err_ready);
  assign drop_s  = event_s & err_valid_r & ~err_ready;

  // Copy classification of the current input.
  always_comb begin
    copy_s = classify_copy(in_a, in_b, in_c, mismatch_s);
  end

  // Voted output register; holds while no valid input arrives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_r       <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        out_r <= vote_s;
      end else begin
        out_r <= out_r;
      end
    end
  end

  // Single-entry error event register; fields frozen while pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_valid_r <= 1'b0;
      err_mask_r  <= {WIDTH{1'b0}};
      err_copy_r  <= TMR_COPY_A;
    end else if (load_s) begin
      err_valid_r <= 1'b1;
      err_mask_r  <= mismatch_s;
      err_copy_r  <= copy_s;
    end else if (drain_s) begin
      err_valid_r <= 1'b0;
      err_mask_r  <= err_mask_r;
      err_copy_r  <= err_copy_r;
    end else begin
      err_valid_r <= err_valid_r;
      err_mask_r  <= err_mask_r;
      err_copy_r  <= err_copy_r;
    end
  end

`ifdef TMR_VOTE_MONITOR_ERRCNT_EN
  logic [CNT_W-1:0] err_cnt_r;

  // Sticky overflow flag; clear has priority over a new drop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf_r <= 1'b0;
    end else if (err_clr) begin
      err_ovf_r <= 1'b0;
    end else if (drop_s) begin
      err_ovf_r <= 1'b1;
    end else begin
      err_ovf_r <= err_ovf_r;
    end
  end

  // Saturating event counter, dropped events included; clear wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (err_clr) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (event_s && (err_cnt_r != {CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + CNT_W'(1);
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr;

  // Sticky overflow flag; only reset clears it in this build.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf_r <= 1'b0;
    end else if (drop_s) begin
      err_ovf_r <= 1'b1;
    end else begin
      err_ovf_r <= err_ovf_r;
    end
  end

  assign err_cnt = {CNT_W{1'b0}};
`endif

  // Scrub sequencer state and period counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= RUN;
      scnt_r  <= {SCNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      scnt_r  <= scnt_s;
    end
  end

  // Scrub sequencer next state: errors restart the period and force an
  // early scrub once the corrected word has reached out.
  always_comb begin
    state_s = state_r;
    scnt_s  = scnt_r;
    case (state_r)
      RUN: begin
        if (event_s) begin
          state_s = SCRUB_ASAP;
          scnt_s  = {SCNT_W{1'b0}};
        end else if (scnt_r == SCNT_LAST) begin
          state_s = SCRUB;
          scnt_s  = {SCNT_W{1'b0}};
        end else begin
          state_s = RUN;
          scnt_s  = scnt_r + SCNT_W'(1);
        end
      end
      SCRUB_ASAP: begin
        state_s = SCRUB;
        scnt_s  = {SCNT_W{1'b0}};
      end
      SCRUB: begin
        state_s = RUN;
        scnt_s  = {SCNT_W{1'b0}};
      end
      default: begin
        state_s = RUN;
        scnt_s  = {SCNT_W{1'b0}};
      end
    endcase
  end

  // Registered scrub strobe, one cycle per SCRUB visit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scrub_r <= 1'b0;
    end else begin
      scrub_r <= (state_r == SCRUB);
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign err_valid = err_valid_r;
  assign err_mask  = err_mask_r;
  assign err_copy  = err_copy_r;
  assign err_ovf   = err_ovf_r;
  assign scrub     = scrub_r;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Self-checking bench for tmr_vote_monitor: directed scenarios followed by
// randomized traffic, with a scoreboard for voted words and error events.
module tb_tmr_vote_monitor;

  localparam int WIDTH = 6;
  localparam int CNT_W = 8;
  localparam int P     = 16;
`ifdef TMR_VOTE_MONITOR_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn;
  logic [WIDTH-1:0] in_a, in_b, in_c;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             err_valid;
  logic             err_ready;
  logic [WIDTH-1:0] err_mask;
  logic [1:0]       err_copy;
  logic             err_ovf;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr;
  logic             scrub;

  tmr_vote_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SCRUB_PERIOD(P)) dut (
    .clk(clk), .rstn(rstn), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_valid(in_valid), .out(out), .out_valid(out_valid),
    .err_valid(err_valid), .err_ready(err_ready), .err_mask(err_mask),
    .err_copy(err_copy), .err_ovf(err_ovf), .err_cnt(err_cnt),
    .err_clr(err_clr), .scrub(scrub)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] mask;
    logic [1:0]       copy;
  } ev_t;

  ev_t              evq[$];
  logic [WIDTH-1:0] outq[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state (values visible after the latest edge, and
  // predicted values for the next edge).
  int  n;
  int  sched;
  bit  locked;
  logic [WIDTH-1:0] exp_out, pend_out;
  bit  exp_ov, pend_ov, exp_ev, pend_ev, exp_ovf, pend_ovf, exp_scrub, pend_scrub;
  int  exp_cnt, pend_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-bit majority, disagreement, and minority-copy identification.
  function automatic void ref_vote(input logic [WIDTH-1:0] a, b, c,
                                   output logic [WIDTH-1:0] v, d,
                                   output logic [1:0] cp);
    int minority = -1;
    bit multi = 1'b0;
    v = '0;
    d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      int mi;
      v[i] = (ones >= 2);
      d[i] = (ones == 1) || (ones == 2);
      if (d[i]) begin
        if (ones == 1) mi = a[i] ? 0 : (b[i] ? 1 : 2);
        else           mi = !a[i] ? 0 : (!b[i] ? 1 : 2);
        if (minority < 0) minority = mi;
        else if (minority != mi) multi = 1'b1;
      end
    end
    cp = multi ? 2'd3 : ((minority < 0) ? 2'd0 : 2'(minority));
  endfunction

  // Predict the effect of the currently driven inputs at edge n+1.
  task automatic predict();
    logic [WIDTH-1:0] v, d;
    logic [1:0] cp;
    bit ev, drain, dropped, scrub_now;
    int m = n + 1;
    ref_vote(in_a, in_b, in_c, v, d, cp);
    ev = in_valid && (d != '0);
    pend_out = exp_out;
    pend_ov  = in_valid;
    if (in_valid) begin
      pend_out = v;
      outq.push_back(v);
    end
    drain   = exp_ev && err_ready;
    dropped = 1'b0;
    pend_ev = exp_ev;
    if (ev) begin
      if (!exp_ev || drain) begin
        pend_ev = 1'b1;
        evq.push_back('{mask: d, copy: cp});
      end else begin
        dropped = 1'b1;
      end
    end else if (drain) begin
      pend_ev = 1'b0;
    end
    pend_ovf = exp_ovf;
    if (CNT_EN && err_clr) pend_ovf = 1'b0;
    else if (dropped)      pend_ovf = 1'b1;
    pend_cnt = exp_cnt;
    if (CNT_EN) begin
      if (err_clr) pend_cnt = 0;
      else if (ev && exp_cnt < (1 << CNT_W) - 1) pend_cnt = exp_cnt + 1;
    end
    scrub_now  = (sched == m);
    pend_scrub = scrub_now;
    if (ev && !scrub_now && !(locked && sched == m + 1)) begin
      sched  = m + 2;
      locked = 1'b1;
    end else if (scrub_now) begin
      sched  = m + P;
      locked = 1'b0;
    end
  endtask

  task automatic cycle(input logic [WIDTH-1:0] a, b, c, input logic v, rdy, clr);
    @(posedge clk);
    exp_out = pend_out; exp_ov = pend_ov; exp_ev = pend_ev;
    exp_ovf = pend_ovf; exp_cnt = pend_cnt; exp_scrub = pend_scrub;
    n++;
    #1;
    in_a = a; in_b = b; in_c = c; in_valid = v; err_ready = rdy; err_clr = clr;
    predict();
  endtask

  task automatic idle(input int cnt, input logic rdy);
    for (int i = 0; i < cnt; i++) cycle('0, '0, '0, 1'b0, rdy, 1'b0);
  endtask

  // Caller has already pulled rstn low (or this is power-on).
  task automatic reset_model();
    rstn = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_valid = 1'b0; err_ready = 1'b0; err_clr = 1'b0;
    evq.delete(); outq.delete();
    exp_out = '0; exp_ov = 0; exp_ev = 0; exp_ovf = 0; exp_cnt = 0; exp_scrub = 0;
    pend_out = '0; pend_ov = 0; pend_ev = 0; pend_ovf = 0; pend_cnt = 0; pend_scrub = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    n = 0; sched = P; locked = 1'b0;
    predict();
  endtask

  // Monitor: cycle-level expectations plus scoreboard pops on handshakes.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk("out", out, exp_out);
      chk("out_valid", out_valid, exp_ov);
      chk("err_valid", err_valid, exp_ev);
      chk("err_ovf", err_ovf, exp_ovf);
      chk("err_cnt", err_cnt, exp_cnt);
      chk("scrub", scrub, exp_scrub);
      if (out_valid === 1'b1) begin
        if (outq.size() == 0) chk("sb_out_empty", 32'd1, 32'd0);
        else chk("sb_out", out, outq.pop_front());
      end
      if (err_valid === 1'b1) begin
        if (evq.size() == 0) chk("sb_ev_empty", 32'd1, 32'd0);
        else begin
          chk("sb_ev_mask", err_mask, evq[0].mask);
          chk("sb_ev_copy", err_copy, evq[0].copy);
          if (err_ready === 1'b1) void'(evq.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] base;
    reset_model();

    // Clean vote, then idle long enough to see periodic scrubs.
    cycle(6'h2A, 6'h2A, 6'h2A, 1'b1, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("clean_out", out, 6'h2A);
    chk("clean_err_valid", err_valid, 1'b0);
    idle(40, 1'b1);

    // Single-copy flip on B, held by backpressure.
    cycle(6'h2A, 6'h2B, 6'h2A, 1'b1, 1'b0, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("flip_out", out, 6'h2A);
    chk("flip_mask", err_mask, 6'h01);
    chk("flip_copy", err_copy, 2'd1);
    chk("flip_cnt", err_cnt, CNT_EN ? 8'd1 : 8'd0);
    idle(3, 1'b1);

    // Multi-copy disagreement.
    cycle(6'h01, 6'h02, 6'h00, 1'b1, 1'b0, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("multi_out", out, 6'h00);
    chk("multi_mask", err_mask, 6'h03);
    chk("multi_copy", err_copy, 2'd3);
    idle(2, 1'b1);

    // Backpressure and overflow: two events while not ready.
    cycle(6'h10, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0);
    cycle(6'h00, 6'h00, 6'h04, 1'b1, 1'b0, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("bp_ovf", err_ovf, 1'b1);
    chk("bp_mask", err_mask, 6'h10);
    chk("bp_copy", err_copy, 2'd0);
    cycle('0, '0, '0, 1'b0, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("bp_drained", err_valid, 1'b0);

    // Saturation and clear-vs-increment.
    cycle('0, '0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 260; i++)
      cycle(6'h15, 6'h15, 6'(1 << (i % WIDTH)) ^ 6'h15, 1'b1, 1'b1, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("sat_cnt", err_cnt, CNT_EN ? 8'hFF : 8'h00);
    cycle(6'h3F, 6'h3E, 6'h3F, 1'b1, 1'b1, 1'b1);
    cycle('0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("clr_cnt", err_cnt, 8'h00);
    idle(4, 1'b1);

    // Asynchronous reset while an event is pending.
    cycle(6'h07, 6'h07, 6'h06, 1'b1, 1'b0, 1'b0);
    cycle('0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_err_valid", err_valid, 1'b1);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_out", out, 6'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err_valid", err_valid, 1'b0);
    chk("rst_err_mask", err_mask, 6'h00);
    chk("rst_err_copy", err_copy, 2'd0);
    chk("rst_err_ovf", err_ovf, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'h00);
    chk("rst_scrub", scrub, 1'b0);
    reset_model();
    idle(36, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [WIDTH-1:0] a, b, c;
      base = WIDTH'($urandom);
      a = base; b = base; c = base;
      if ($urandom_range(0, 3) == 0) a = a ^ WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) b = b ^ WIDTH'($urandom);
      if ($urandom_range(0, 5) == 0) c = c ^ WIDTH'($urandom);
      cycle(a, b, c, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 63) == 0));
    end

    idle(6, 1'b1);
    chk("sb_out_leftover", outq.size(), 32'd0);
    chk("sb_ev_leftover", evq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
